simmem_resp_bank: RTL and testbench
===================================

SIMMEM_RESP_BANK -- requirements
Module: simmem_resp_bank

Interface
REQ-001 Parameter IDWidth, default 2, SHALL set ID width; NumIds = 2**IDWidth.
REQ-002 Parameter Capacity, default 8, SHALL set total stored responses shared across all IDs.
REQ-003 Parameter DataWidth, default 8, SHALL set the response payload width, excluding the ID.
REQ-004 clk_i  input  1  SHALL be the single clock; all state rises on posedge.
REQ-005 rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 in_valid_i  input  1  SHALL indicate an incoming response.
REQ-007 in_ready_o  output  1  SHALL indicate a free slot.
REQ-008 in_id_i  input  IDWidth  SHALL carry the incoming response ID.
REQ-009 in_data_i  input  DataWidth  SHALL carry the incoming response payload.
REQ-010 release_en_i  input  NumIds  SHALL carry the per-ID release permission from the releaser.
REQ-011 out_valid_o  output  1  SHALL indicate a released response.
REQ-012 out_ready_i  input  1  SHALL indicate downstream acceptance.
REQ-013 out_id_o  output  IDWidth  SHALL carry the released response ID.
REQ-014 out_data_o  output  DataWidth  SHALL carry the released response payload.

Function
REQ-015 Storage SHALL be Capacity slots holding {data, next-pointer}, a free bitmap, and per-ID head, tail and count; count width SHALL be $clog2(Capacity+1).
REQ-016 in_ready_o SHALL be 1 iff at least one slot is free at cycle start; a same-cycle pop SHALL NOT raise it.
REQ-017 On in_valid_i&in_ready_o the bank SHALL write the lowest-index free slot and append it to the tail of in_id_i's queue, preserving per-ID FIFO order.
REQ-018 A stored response SHALL be eligible for release no earlier than the cycle after acceptance (1-cycle latency).
REQ-019 ID i SHALL be eligible iff count[i]>0 and release_en_i[i]=1.
REQ-020 Selection SHALL be round-robin: first eligible ID at or after rr_ptr, wrapping at NumIds-1 to 0.
REQ-021 out_valid_o SHALL be 1 iff locked or any ID is eligible; out_id_o/out_data_o SHALL show the selected or locked ID's head.
REQ-022 If out_valid_o=1 and out_ready_i=0, the block SHALL lock onto that ID; while locked, out_id_o/out_data_o SHALL stay stable even if release_en_i drops.
REQ-023 On out_valid_o&out_ready_i the block SHALL pop the head, free its slot, clear the lock and set rr_ptr to (ID+1) mod NumIds.
REQ-024 Simultaneous push and pop SHALL both complete; a push to an ID with count 0 SHALL NOT be popped in the same cycle.
REQ-025 A freed slot SHALL be reusable from the next cycle.
REQ-026 Sole empty-queue condition: all counts 0 -> out_valid_o=0, X-free outputs.

Reset
REQ-027 While rst_i=1: free bitmap all-free, all counts 0, rr_ptr 0, lock cleared, in_ready_o=1, out_valid_o=0, out_id_o=0, out_data_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored responses immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro SIMMEM_RESP_BANK_OUT_REG_EN defined: a one-entry output register SHALL drive out_*.
  - Register loads the arbiter's pop when empty or drained the same cycle.
  - Latency becomes 2 cycles; REQ-022 lock SHALL be omitted.
  - Register reset SHALL be empty.
REQ-030 Macro undefined: out_* SHALL be driven combinationally from bank state per REQ-021/022.

Verification
REQ-031 Reset, then push ID1 data 0xA5 with release_en_i=4'b0010 and out_ready_i=1 -> out_valid_o=1 with out_id_o=1, out_data_o=0xA5 the next cycle (two cycles with macro).
REQ-032 Fill 8 responses with release_en_i=0 -> in_ready_o=0 after 8th; a 9th in_valid_i is not accepted; raise release_en_i[0] -> slots freed, in_ready_o=1 the cycle after the first pop.
REQ-033 Push ID2: 0x11, 0x22, 0x33 with release always on -> released in order 0x11, 0x22, 0x33.
REQ-034 IDs 0-3 each hold one entry, release_en_i=4'hF, out_ready_i=1 -> IDs released 0, 1, 2, 3.
REQ-035 out_valid_o with ID3, out_ready_i=0, then drop release_en_i[3] -> out_id_o=3 and out_data_o unchanged until out_ready_i=1 (macro undefined).
REQ-036 Assert rst_i asynchronously with 5 entries stored -> out_valid_o=0 and in_ready_o=1 before the next clock edge.

Source files
------------

// File: rtl/simmem_resp_bank.sv
// Response bank: shared slot pool with per-ID linked-list FIFOs and a round-robin releaser.
// Define SIMMEM_RESP_BANK_OUT_REG_EN to drive out_* from a one-entry output register.
module simmem_resp_bank #(
  parameter int IDWidth   = 2,
  parameter int Capacity  = 8,
  parameter int DataWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IDWidth-1:0]     in_id_i,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic [2**IDWidth-1:0]  release_en_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IDWidth-1:0]     out_id_o,
  output logic [DataWidth-1:0]   out_data_o
);

  localparam int NumIds = 2**IDWidth;
  localparam int SlotW  = (Capacity > 1) ? $clog2(Capacity) : 1;
  localparam int CntW   = $clog2(Capacity + 1);

  typedef logic [SlotW-1:0]   slot_t;
  typedef logic [CntW-1:0]    cnt_t;
  typedef logic [IDWidth-1:0] id_t;

  // Slot storage and per-ID queue bookkeeping.
  logic [DataWidth-1:0] r_data [Capacity];
  slot_t                r_next [Capacity];
  logic [Capacity-1:0]  r_free;
  slot_t                r_head [NumIds];
  slot_t                r_tail [NumIds];
  cnt_t                 r_cnt  [NumIds];
  id_t                  r_rr_ptr;

`ifndef SIMMEM_RESP_BANK_OUT_REG_EN
  logic                 r_locked;
  id_t                  r_lock_id;
`else
  logic                 r_oval;
  id_t                  r_oid;
  logic [DataWidth-1:0] r_odata;
`endif

  logic [NumIds-1:0]    w_eligible;
  logic                 w_rr_valid;
  id_t                  w_rr_id;
  id_t                  w_cand;
  logic                 w_arb_valid;
  id_t                  w_arb_id;
  slot_t                w_sel_slot;
  slot_t                w_free_slot;
  logic                 w_push;
  logic                 w_pop;

  assign in_ready_o = |r_free;
  assign w_push     = in_valid_i & in_ready_o;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_free_slot = '0;
    for (int s = Capacity - 1; s >= 0; s--) begin
      if (r_free[s]) w_free_slot = slot_t'(s);
    end
  end

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      w_eligible[i] = (r_cnt[i] != '0) && release_en_i[i];
    end
  end

  // First eligible ID at or after rr_ptr; IDWidth-bit addition wraps naturally.
  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_id    = '0;
    w_cand     = '0;
    for (int k = 0; k < NumIds; k++) begin
      w_cand = r_rr_ptr + id_t'(k);
      if (!w_rr_valid && w_eligible[w_cand]) begin
        w_rr_valid = 1'b1;
        w_rr_id    = w_cand;
      end
    end
  end

`ifndef SIMMEM_RESP_BANK_OUT_REG_EN
  // A stalled offer stays pinned to its ID even if the release permission drops.
  always_comb begin
    w_arb_valid = w_rr_valid;
    w_arb_id    = w_rr_id;
    if (r_locked) begin
      w_arb_valid = 1'b1;
      w_arb_id    = r_lock_id;
    end
  end

  assign w_sel_slot  = r_head[w_arb_id];
  assign w_pop       = w_arb_valid & out_ready_i;
  assign out_valid_o = w_arb_valid;
  assign out_id_o    = w_arb_valid ? w_arb_id : '0;
  assign out_data_o  = w_arb_valid ? r_data[w_sel_slot] : '0;
`else
  assign w_arb_valid = w_rr_valid;
  assign w_arb_id    = w_rr_id;
  assign w_sel_slot  = r_head[w_arb_id];
  // The register takes a new entry when empty or being drained this cycle.
  assign w_pop       = w_arb_valid & (~r_oval | out_ready_i);
  assign out_valid_o = r_oval;
  assign out_id_o    = r_oval ? r_oid : '0;
  assign out_data_o  = r_oval ? r_odata : '0;
`endif

  // NOTE: payload and link storage carry no reset; a slot is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[w_free_slot] <= in_data_i;
      if (r_cnt[in_id_i] != '0) r_next[r_tail[in_id_i]] <= w_free_slot;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_free   <= '1;
      r_head   <= '{default: '0};
      r_tail   <= '{default: '0};
      r_cnt    <= '{default: '0};
      r_rr_ptr <= '0;
    end else begin
      if (w_push) r_free[w_free_slot] <= 1'b0;
      if (w_pop)  r_free[w_sel_slot]  <= 1'b1;
      if (w_pop)  r_rr_ptr <= w_arb_id + id_t'(1);
      for (int i = 0; i < NumIds; i++) begin
        if (w_push && in_id_i == id_t'(i)) begin
          r_tail[i] <= w_free_slot;
          if (!(w_pop && w_arb_id == id_t'(i))) begin
            r_cnt[i] <= r_cnt[i] + cnt_t'(1);
            if (r_cnt[i] == '0) r_head[i] <= w_free_slot;
          end else if (r_cnt[i] == cnt_t'(1)) begin
            // Popping the only entry while appending: the new slot becomes the head.
            r_head[i] <= w_free_slot;
          end else begin
            r_head[i] <= r_next[r_head[i]];
          end
        end else if (w_pop && w_arb_id == id_t'(i)) begin
          r_cnt[i]  <= r_cnt[i] - cnt_t'(1);
          r_head[i] <= r_next[r_head[i]];
        end
      end
    end
  end

`ifndef SIMMEM_RESP_BANK_OUT_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_pop) begin
      r_locked  <= 1'b0;
    end else if (w_arb_valid) begin
      r_locked  <= 1'b1;
      r_lock_id <= w_arb_id;
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_oval  <= 1'b0;
      r_oid   <= '0;
      r_odata <= '0;
    end else if (w_pop) begin
      r_oval  <= 1'b1;
      r_oid   <= w_arb_id;
      r_odata <= r_data[w_sel_slot];
    end else if (out_ready_i) begin
      r_oval  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Directed bench for simmem_resp_bank (default build): scoreboard of expected releases,
// compared by a negedge monitor whenever a response is handed off.
module tb_simmem_resp_bank;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [1:0] in_id_i;
  logic [7:0] in_data_i;
  logic [3:0] release_en_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [1:0] out_id_o;
  logic [7:0] out_data_o;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  simmem_resp_bank #(.IDWidth(2), .Capacity(8), .DataWidth(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_id_i      (in_id_i),
    .in_data_i    (in_data_i),
    .release_en_i (release_en_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_id_o     (out_id_o),
    .out_data_o   (out_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted handoff must match the oldest expected release.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {22'd0, out_id_o, out_data_o}, 32'hFFFF_FFFF);
      end else begin
        item_t e;
        e = sb.pop_front();
        check("out_id", out_id_o, e.id);
        check("out_data", out_data_o, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data, input bit expect_release);
    in_valid_i = 1'b1;
    in_id_i    = id;
    in_data_i  = data;
    if (expect_release) sb.push_back('{id: id, data: data});
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    rst_i        = 1'b1;
    in_valid_i   = 1'b0;
    in_id_i      = '0;
    in_data_i    = '0;
    release_en_i = '0;
    out_ready_i  = 1'b0;
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_id", out_id_o, 0);
    check("rst_out_data", out_data_o, 0);
    step();
    rst_i = 1'b0;

    // Single response, one-cycle release latency.
    release_en_i = 4'b0010;
    out_ready_i  = 1'b1;
    in_valid_i = 1'b1; in_id_i = 2'd1; in_data_i = 8'hA5;
    sb.push_back('{id: 2'd1, data: 8'hA5});
    @(negedge clk_i);
    check("lat_not_yet_valid", out_valid_o, 0);
    step();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("lat_valid", out_valid_o, 1);
    check("lat_id", out_id_o, 1);
    check("lat_data", out_data_o, 8'hA5);
    step();
    @(negedge clk_i);
    check("empty_after_single", out_valid_o, 0);
    step();

    // Fill all slots with release held off, then drain through ID0.
    release_en_i = 4'b0000;
    for (int k = 0; k < 8; k++) push(2'd0, 8'h10 + 8'(k), 1'b1);
    @(negedge clk_i);
    check("full_ready_low", in_ready_o, 0);
    check("full_no_release", out_valid_o, 0);
    step();
    in_valid_i = 1'b1; in_id_i = 2'd0; in_data_i = 8'hEE;
    @(negedge clk_i);
    check("ninth_blocked", in_ready_o, 0);
    step();
    in_valid_i   = 1'b0;
    release_en_i = 4'b0001;
    @(negedge clk_i);
    check("pop_cycle_ready_low", in_ready_o, 0);
    step();
    @(negedge clk_i);
    check("ready_after_pop", in_ready_o, 1);
    step();
    wait_drain("drain_full", 20);
    @(negedge clk_i);
    check("ninth_never_stored", out_valid_o, 0);
    step();

    // Back-to-back pushes to one ID with release always on: FIFO order kept.
    release_en_i = 4'b0100;
    in_valid_i = 1'b1; in_id_i = 2'd2;
    in_data_i = 8'h11; sb.push_back('{id: 2'd2, data: 8'h11}); step();
    in_data_i = 8'h22; sb.push_back('{id: 2'd2, data: 8'h22}); step();
    in_data_i = 8'h33; sb.push_back('{id: 2'd2, data: 8'h33}); step();
    in_valid_i = 1'b0;
    wait_drain("drain_fifo_order", 10);

    // Round-robin from a fresh rr pointer.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    release_en_i = 4'b0000;
    for (int k = 0; k < 4; k++) push(2'(k), 8'hD0 + 8'(k), 1'b1);
    release_en_i = 4'hF;
    wait_drain("drain_round_robin", 10);

    // Lock: stalled ID3 offer must survive its permission dropping.
    out_ready_i  = 1'b0;
    release_en_i = 4'b1000;
    push(2'd3, 8'h3C, 1'b1);
    push(2'd1, 8'h1C, 1'b1);
    @(negedge clk_i);
    check("lock_valid", out_valid_o, 1);
    check("lock_id", out_id_o, 3);
    check("lock_data", out_data_o, 8'h3C);
    step();
    release_en_i = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("locked_valid", out_valid_o, 1);
      check("locked_id", out_id_o, 3);
      check("locked_data", out_data_o, 8'h3C);
      step();
    end
    out_ready_i = 1'b1;
    wait_drain("drain_after_lock", 10);

    // Asynchronous reset with entries stored.
    out_ready_i  = 1'b0;
    release_en_i = 4'hF;
    push(2'd0, 8'h50, 1'b0);
    push(2'd1, 8'h51, 1'b0);
    push(2'd2, 8'h52, 1'b0);
    push(2'd3, 8'h53, 1'b0);
    push(2'd0, 8'h54, 1'b0);
    @(negedge clk_i);
    check("pre_rst_valid", out_valid_o, 1);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", out_valid_o, 0);
    check("async_rst_ready", in_ready_o, 1);
    check("async_rst_id", out_id_o, 0);
    check("async_rst_data", out_data_o, 0);
    step();
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("post_rst_empty", out_valid_o, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
